// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and controller state encoding for the burst RAM path
package mem_pkg;
  localparam int DEPTH_BITS = 6;
  localparam int DATA_BITS = 8;
  localparam int LEN_BITS = 4;
  typedef enum logic [1:0] {IDLE, WRITE, READ} ctrl_state_t;
endpackage

// File: rtl/mem_burst_ctrl_ram.sv
// ram_64x8: single-port synchronous RAM; ports clk/rst, enable, read_write (1=write), address, data_input, registered data_output
module ram_64x8
  import mem_pkg::*;
#(
  parameter int AW = DEPTH_BITS,
  parameter int DW = DATA_BITS
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          read_write,
  input  logic [AW-1:0] address,
  input  logic [DW-1:0] data_input,
  output logic [DW-1:0] data_output
);
  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] data_output_d, data_output_q;
  assign data_output_d = (enable && !read_write) ? mem[address] : data_output_q;
  assign data_output = data_output_q;
  always_ff @(posedge clk) begin
    if (rst) data_output_q <= '0;
    else data_output_q <= data_output_d;
  end
  // storage is deliberately left out of reset so contents survive a controller reset
  always_ff @(posedge clk) begin
    if (enable && read_write) mem[address] <= data_input;
  end
endmodule

// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: sequences read/write bursts (req_*) into single-beat RAM accesses; wr_* streams write beats in, rd_* streams read beats out, busy flags a burst in flight
module mem_burst_ctrl
  import mem_pkg::*;
#(
  parameter int DEPTH_BITS = mem_pkg::DEPTH_BITS,
  parameter int DATA_BITS = mem_pkg::DATA_BITS,
  parameter int LEN_BITS = mem_pkg::LEN_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [DEPTH_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]   req_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_BITS-1:0]  wr_data,
  output logic                  rd_valid,
  output logic [DATA_BITS-1:0]  rd_data,
  output logic                  rd_last,
  output logic                  busy
);
  ctrl_state_t state_d, state_q;
  logic [DEPTH_BITS-1:0] addr_d, addr_q;
  logic [LEN_BITS-1:0] cnt_d, cnt_q;
  logic rd_valid_d, rd_valid_q, rd_last_d, rd_last_q;
  logic ram_en, ram_rw;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    ram_en = 1'b0;
    ram_rw = 1'b0;
    rd_valid_d = 1'b0;
    rd_last_d = 1'b0;
    case (state_q)
      IDLE: if (req_valid) begin
        addr_d = req_addr;
        cnt_d = req_len;
        state_d = req_write ? WRITE : READ;
      end
      WRITE: if (wr_valid) begin
        ram_en = 1'b1;
        ram_rw = 1'b1;
        addr_d = addr_q + 1'b1;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? IDLE : WRITE;
      end
      READ: begin
        ram_en = 1'b1;
        rd_valid_d = 1'b1;
        rd_last_d = (cnt_q == '0);
        addr_d = addr_q + 1'b1;
        cnt_d = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        state_d = (cnt_q == '0) ? IDLE : READ;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q <= rd_last_d;
    end
  end
  assign req_ready = (state_q == IDLE);
  assign wr_ready = (state_q == WRITE);
  assign busy = (state_q != IDLE);
  assign rd_valid = rd_valid_q;
  assign rd_last = rd_last_q;
  ram_64x8 #(.AW(DEPTH_BITS), .DW(DATA_BITS)) u_ram (
    .clk(clk),
    .rst(rst),
    .enable(ram_en),
    .read_write(ram_rw),
    .address(addr_q),
    .data_input(wr_data),
    .data_output(rd_data)
  );
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: directed bursts checked per cycle against a cycle-indexed expectation model
module tb_mem_burst_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic req_valid = 1'b0, req_write = 1'b0, wr_valid = 1'b0;
  logic [5:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic [7:0] wr_data = '0;
  logic req_ready, wr_ready, rd_valid, rd_last, busy;
  logic [7:0] rd_data;
  mem_burst_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .busy(busy)
  );
  always #5 clk = ~clk;
  int cyc = 0, n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] mem_m [64];
  bit exp_v [4096], exp_l [4096], exp_busy [4096], exp_wr [4096];
  logic [7:0] exp_d [4096];
  logic [7:0] wbuf [16];
  logic [7:0] got_d [$];
  bit got_l [$];
  int got_c [$];
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  always @(negedge clk) if (chk_en) begin
    check("rd_valid", 32'(rd_valid), 32'(exp_v[cyc]));
    check("busy", 32'(busy), 32'(exp_busy[cyc]));
    check("req_ready", 32'(req_ready), 32'(!exp_busy[cyc]));
    check("wr_ready", 32'(wr_ready), 32'(exp_wr[cyc]));
    if (rd_valid) begin
      check("rd_data", 32'(rd_data), 32'(exp_d[cyc]));
      check("rd_last", 32'(rd_last), 32'(exp_l[cyc]));
      got_d.push_back(rd_data);
      got_l.push_back(rd_last);
      got_c.push_back(cyc);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_got();
    got_d.delete();
    got_l.delete();
    got_c.delete();
  endtask
  task automatic write_burst(input logic [5:0] a, input logic [3:0] l, input int stall);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr = a;
    req_len = l;
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= int'(l); i++) begin
      if (i == 1) repeat (stall) begin
        wr_valid = 1'b0;
        exp_busy[cyc] = 1'b1;
        exp_wr[cyc] = 1'b1;
        tick();
      end
      wr_valid = 1'b1;
      wr_data = wbuf[i];
      exp_busy[cyc] = 1'b1;
      exp_wr[cyc] = 1'b1;
      mem_m[(int'(a) + i) % 64] = wbuf[i];
      tick();
    end
    wr_valid = 1'b0;
  endtask
  task automatic read_burst(input logic [5:0] a, input logic [3:0] l);
    int k = cyc;
    int n = int'(l) + 1;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = a;
    req_len = l;
    for (int i = 0; i < n; i++) begin
      exp_busy[k + 1 + i] = 1'b1;
      exp_v[k + 2 + i] = 1'b1;
      exp_d[k + 2 + i] = mem_m[(int'(a) + i) % 64];
      exp_l[k + 2 + i] = (i == n - 1);
    end
    tick();
    req_valid = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    tick();
    chk_en = 1'b1;
    tick();
    check("reset rd_data", 32'(rd_data), 32'h0);
    check("reset rd_last", 32'(rd_last), 32'h0);
    check("reset req_ready", 32'(req_ready), 32'h1);
    rst = 1'b0;
    tick();
    wbuf[0] = 8'h02;
    write_burst(6'd1, 4'd0, 0);
    clear_got();
    read_burst(6'd1, 4'd0);
    tick();
    check("single count", 32'(got_d.size()), 32'd1);
    if (got_d.size() == 1) begin
      check("single data", 32'(got_d[0]), 32'h02);
      check("single last", 32'(got_l[0]), 32'h1);
    end
    for (int i = 0; i < 4; i++) wbuf[i] = 8'hA0 + 8'(i);
    write_burst(6'd62, 4'd3, 0);
    clear_got();
    read_burst(6'd62, 4'd3);
    tick();
    check("wrap count", 32'(got_d.size()), 32'd4);
    if (got_d.size() == 4) for (int i = 0; i < 4; i++) begin
      check("wrap data", 32'(got_d[i]), 32'(8'hA0 + 8'(i)));
      check("wrap last", 32'(got_l[i]), 32'(i == 3));
    end
    wbuf[0] = 8'hEE;
    write_burst(6'd13, 4'd0, 0);
    wbuf[0] = 8'h31;
    wbuf[1] = 8'h32;
    wbuf[2] = 8'h33;
    write_burst(6'd10, 4'd2, 2);
    clear_got();
    read_burst(6'd10, 4'd3);
    tick();
    check("stall count", 32'(got_d.size()), 32'd4);
    if (got_d.size() == 4) begin
      check("stall d0", 32'(got_d[0]), 32'h31);
      check("stall d1", 32'(got_d[1]), 32'h32);
      check("stall d2", 32'(got_d[2]), 32'h33);
      check("stall sentinel", 32'(got_d[3]), 32'hEE);
    end
    wr_valid = 1'b1;
    wr_data = 8'hFF;
    repeat (2) tick();
    wr_valid = 1'b0;
    clear_got();
    read_burst(6'd13, 4'd0);
    tick();
    if (got_d.size() == 1) check("idle write ignored", 32'(got_d[0]), 32'hEE);
    else check("idle write count", 32'(got_d.size()), 32'd1);
    for (int i = 0; i < 16; i++) wbuf[i] = 8'(i);
    write_burst(6'd0, 4'd15, 0);
    clear_got();
    k = cyc;
    read_burst(6'd0, 4'd15);
    tick();
    check("max count", 32'(got_d.size()), 32'd16);
    if (got_d.size() == 16) begin
      for (int i = 0; i < 16; i++) check("max data", 32'(got_d[i]), 32'(i));
      check("max first latency", 32'(got_c[0] - k), 32'd2);
      check("max contiguous", 32'(got_c[15] - got_c[0]), 32'd15);
    end
    clear_got();
    read_burst(6'd1, 4'd1);
    read_burst(6'd62, 4'd0);
    tick();
    check("b2b count", 32'(got_d.size()), 32'd3);
    if (got_d.size() == 3) begin
      check("b2b d0", 32'(got_d[0]), 32'h01);
      check("b2b d1", 32'(got_d[1]), 32'h02);
      check("b2b d2", 32'(got_d[2]), 32'hA0);
      check("b2b last0", 32'(got_l[0]), 32'h0);
      check("b2b last1", 32'(got_l[1]), 32'h1);
      check("b2b last2", 32'(got_l[2]), 32'h1);
      check("b2b gap", 32'(got_c[2] - got_c[1]), 32'd2);
    end
    for (int i = 0; i < 8; i++) wbuf[i] = 8'h50 + 8'(i);
    write_burst(6'd20, 4'd7, 0);
    k = cyc;
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr = 6'd20;
    req_len = 4'd7;
    for (int i = 0; i < 2; i++) begin
      exp_v[k + 2 + i] = 1'b1;
      exp_d[k + 2 + i] = mem_m[20 + i];
      exp_l[k + 2 + i] = 1'b0;
    end
    for (int i = 1; i <= 3; i++) exp_busy[k + i] = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst rd_valid", 32'(rd_valid), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst req_ready", 32'(req_ready), 32'h1);
    check("rst rd_data", 32'(rd_data), 32'h0);
    clear_got();
    read_burst(6'd20, 4'd7);
    tick();
    check("post-rst count", 32'(got_d.size()), 32'd8);
    if (got_d.size() == 8) for (int i = 0; i < 8; i++)
      check("post-rst data", 32'(got_d[i]), 32'(8'h50 + 8'(i)));
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_burst_ctrl.md
# mem_burst_ctrl

Burst request controller sitting directly upstream of the team's 64 x 8 single-port synchronous RAM. Accepts read/write burst requests over a valid/ready handshake and sequences them into single-beat RAM accesses with auto-incrementing, wrapping addresses. Streams write data in and read data out, aligning read beats to the RAM's one-cycle read latency. Instantiates the RAM internally, so the whole storage path is one drop-in block.

## Interface
- `DEPTH_BITS`, 6: RAM address width (64 locations).
- `DATA_BITS`, 8: RAM data width.
- `LEN_BITS`, 4: burst length field width; beats = `req_len` + 1 (1..16).

- `clk` in 1: single clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in 1: burst request present.
- `req_ready` out 1: controller can accept a request.
- `req_write` in 1: 1 = write burst, 0 = read burst.
- `req_addr` in 6: start address.
- `req_len` in 4: beats minus one.
- `wr_valid` in 1: write beat present.
- `wr_ready` out 1: write beat accepted this cycle.
- `wr_data` in 8: write beat data.
- `rd_valid` out 1: read beat valid. No backpressure.
- `rd_data` out 8: read beat data.
- `rd_last` out 1: qualifies the final read beat of a burst.
- `busy` out 1: burst in progress (state != IDLE).

## Operation
- States: IDLE, WRITE, READ.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid` && `req_ready`, latch `req_addr` into the address counter and `req_len` into the remaining-beat counter.
  - Go to WRITE if `req_write` = 1, else READ.
- WRITE:
  - `wr_ready` = 1; RAM enable = `wr_valid`; read_write = 1; RAM address = address counter; RAM data = `wr_data`.
  - On each accepted beat, address counter +1 modulo 64, so 63 wraps to 0.
  - When an accepted beat finds the remaining count at 0, go to IDLE. Otherwise decrement the count.
  - A `wr_valid` = 0 cycle stalls the burst; no RAM access occurs.
- READ:
  - RAM enable = 1 and read_write = 0 every cycle; address counter increments with the same wrap.
  - On the issue with remaining count = 0, set the last-issue flag and go to IDLE.
- Read return path:
  - Two registers, `rd_valid_q` and `rd_last_q`, load the issue/last flags of the issuing cycle.
  - `rd_data` is the RAM output register, passed through.
- `req_ready`, `wr_ready` and `busy` are combinational decodes of state.
- Write beats carrying `wr_valid` while not in WRITE are ignored (`wr_ready` = 0).
- Reset mid-burst:
  - State goes to IDLE and both counters clear; `rd_valid` = 0 the next cycle.
  - Beats not yet issued are abandoned.
  - Already-written RAM locations keep their contents (RAM array is not reset).

## Timing
- Reset values:
  - `req_ready` = 1; `wr_ready` = 0; `busy` = 0.
  - `rd_valid` = 0; `rd_last` = 0; `rd_data` = 0 (RAM output register cleared).
- Request accepted at edge E0; the first RAM access is issued in the cycle after E0.
- Write burst of N beats with `wr_valid` held high: N consecutive cycles in WRITE. `req_ready` returns the cycle after the last beat's edge.
- Read latency:
  - A beat issued in cycle C appears with `rd_valid` = 1 in cycle C+1.
  - A read burst of N beats produces N consecutive `rd_valid` cycles, starting two cycles after the acceptance cycle.
  - `rd_last` = 1 on the Nth beat only.
- Back-to-back requests:
  - A new request may be accepted in the cycle where the previous read burst's final `rd_valid` is presented.
  - A following read adds no bubble beyond the one issue cycle.
- Throughput: one beat per cycle, both directions.

## Structure
- Shared package `mem_pkg`:
  - `DEPTH_BITS`, `DATA_BITS`, `LEN_BITS`.
  - State enum `ctrl_state_t` {IDLE, WRITE, READ}.
- Sub-module `ram_64x8`: single-port synchronous RAM.
  - Ports: `clk`, `enable`, `read_write`, `address`, `data_input`, `data_output`.
  - Write on enable && read_write; registered read on enable && !read_write.
  - Array storage is `DATA_BITS` wide.
  - `data_output` resets to 0 on `rst`.
- Controller FSM, counters and read-return registers live in `mem_burst_ctrl`.

## Test plan
- Single write then single read:
  - Stimulus: write addr 1, len 0, data 0x02; then read addr 1, len 0.
  - Response: `rd_valid` for one cycle with `rd_data` = 0x02 and `rd_last` = 1.
- Wrap-around burst:
  - Stimulus: write addr 62, len 3, data 0xA0..0xA3; then read addr 62, len 3.
  - Response: 0xA0, 0xA1, 0xA2, 0xA3 (locations 62, 63, 0, 1) on 4 consecutive cycles; `rd_last` only on 0xA3.
- Write stall:
  - Stimulus: write len 2 with `wr_valid` low for 2 cycles between beats 0 and 1.
  - Response: exactly 3 RAM writes; `busy` stays high through the stall; readback matches.
- Max burst:
  - Stimulus: write addr 0, len 15, data = address; then read addr 0, len 15.
  - Response: 16 consecutive `rd_valid` beats with data 0..15; first beat 2 cycles after acceptance.
- Back-to-back reads:
  - Stimulus: read addr 1, len 1, immediately followed by read addr 62, len 0.
  - Response: 3 `rd_valid` beats with a single-cycle gap; `rd_last` on beats 2 and 3.
- Reset mid-read:
  - Stimulus: assert `rst` on the 2nd beat of a len-7 read.
  - Response: next cycle `rd_valid` = 0, `busy` = 0, `req_ready` = 1; a subsequent read returns the data written before the reset.
